mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_ADDR_BITS, default 28, memory line-address width.
REQ-002 SHALL have parameter MEM_DATA_BITS, default 128, width of one memory data beat.
REQ-003 SHALL have parameter BEATS, default 4, beats per line for both reads and writes.
REQ-004 SHALL have parameter TAG_DEPTH, default 4, maximum outstanding reads (power of 2).
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port ic_req_val, input, 1, instruction-cache request valid.
REQ-008 SHALL have port ic_req_rdy, output, 1, request accepted this cycle when high with ic_req_val.
REQ-009 SHALL have port ic_req_addr, input, MEM_ADDR_BITS, line address.
REQ-010 SHALL have port ic_req_rw, input, 1, 1 = write, 0 = read.
REQ-011 SHALL have port ic_req_data_valid, input, 1, write data beat valid.
REQ-012 SHALL have port ic_req_data_ready, output, 1, write data beat taken.
REQ-013 SHALL have port ic_req_data_bits, input, MEM_DATA_BITS, write data beat.
REQ-014 SHALL have port ic_req_data_mask, input, MEM_DATA_BITS/8, byte write mask.
REQ-015 SHALL have ports ic_resp_val, output, 1, and ic_resp_data, output, MEM_DATA_BITS, read response beat.
REQ-016 SHALL have a dc_* port set (data cache) identical in name suffix, direction and width to REQ-007..REQ-015.
REQ-017 SHALL have outputs mem_req_val (1), mem_req_addr (MEM_ADDR_BITS), mem_req_rw (1), input mem_req_rdy (1).
REQ-018 SHALL have outputs mem_req_data_valid (1), mem_req_data_bits (MEM_DATA_BITS), mem_req_data_mask (MEM_DATA_BITS/8), input mem_req_data_ready (1).
REQ-019 SHALL have inputs mem_resp_val (1) and mem_resp_data (MEM_DATA_BITS), in-order read return.
REQ-020 SHALL have output err_spurious, 1, sticky flag for a response beat with no outstanding read.

Function
REQ-021 SHALL implement states IDLE and WDATA; requests are only granted in IDLE.
REQ-022 In IDLE, SHALL select one requester: the sole requester, or on contention the one not granted last (round-robin, last-grant register resets to ic so dc wins first tie).
REQ-023 SHALL drive mem_req_val/addr/rw combinationally from the selected client; the selected client's req_rdy = mem_req_rdy, the other's = 0.
REQ-024 SHALL block (val and rdy 0) a selected read when the tag FIFO holds TAG_DEPTH entries; no bypass on same-cycle pop.
REQ-025 On an accepted read, SHALL push owner id (0 = ic, 1 = dc) into the tag FIFO the same edge and stay IDLE.
REQ-026 On an accepted write, SHALL latch owner, clear beat counter, enter WDATA next cycle.
REQ-027 In WDATA, SHALL pass owner's data_valid/bits/mask to mem and mem_req_data_ready back to owner only; other client's data_ready = 0.
REQ-028 In WDATA, SHALL count data handshakes; on handshake with count = BEATS-1 return to IDLE next cycle; mem_req_val = 0 throughout WDATA.
REQ-029 SHALL broadcast mem_resp_data to both resp_data ports; resp_val asserted only for the FIFO-head owner, same cycle as mem_resp_val (zero latency).
REQ-030 SHALL count response beats; on beat BEATS-1 pop the FIFO and clear the counter.
REQ-031 mem_resp_val with empty FIFO SHALL assert no resp_val and set err_spurious until reset.
REQ-032 Reads SHALL be pushable during WDATA? No: no grants in WDATA, but response routing and pops SHALL continue in any state.

Reset
REQ-033 While reset high, SHALL drive all *_rdy, *_val, *_data_ready, mem_req_data_valid outputs 0 and err_spurious 0.
REQ-034 Reset SHALL asynchronously force IDLE, empty FIFO, beat counters 0, last-grant = ic; in-flight transactions are abandoned.

Verification
REQ-035 ic read addr 0x10, mem_req_rdy=1 -> one-cycle accept; 4 mem_resp beats 0xA..0xD -> ic_resp_val 4 cycles with that data, dc_resp_val 0.
REQ-036 ic and dc read simultaneously, mem_req_rdy=1 -> dc granted cycle 1, ic cycle 2; responses route dc then ic.
REQ-037 dc write addr 0x20, 4 beats mask 0xFFFF, mem_req_data_ready toggling 1/0 -> exactly 4 beats forwarded, IDLE after last; ic read held off meanwhile.
REQ-038 5 back-to-back reads, no responses -> 4 accepted, 5th rdy 0 until first line's 4th beat returns, accepted cycle after.
REQ-039 mem_resp_val with empty FIFO -> no resp_val, err_spurious 1; reset mid-write-beat 2 -> IDLE, err_spurious 0, all valids 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-client (icache/dcache) arbiter onto one memory port: round-robin request grant,
// multi-beat write forwarding, and in-order read-response routing through an owner-tag FIFO.
module mem_arbiter #(
  parameter int MEM_ADDR_BITS = 28,
  parameter int MEM_DATA_BITS = 128,
  parameter int BEATS         = 4,
  parameter int TAG_DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       reset,

  input  logic                       ic_req_val,
  output logic                       ic_req_rdy,
  input  logic [MEM_ADDR_BITS-1:0]   ic_req_addr,
  input  logic                       ic_req_rw,
  input  logic                       ic_req_data_valid,
  output logic                       ic_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0]   ic_req_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] ic_req_data_mask,
  output logic                       ic_resp_val,
  output logic [MEM_DATA_BITS-1:0]   ic_resp_data,

  input  logic                       dc_req_val,
  output logic                       dc_req_rdy,
  input  logic [MEM_ADDR_BITS-1:0]   dc_req_addr,
  input  logic                       dc_req_rw,
  input  logic                       dc_req_data_valid,
  output logic                       dc_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0]   dc_req_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] dc_req_data_mask,
  output logic                       dc_resp_val,
  output logic [MEM_DATA_BITS-1:0]   dc_resp_data,

  output logic                       mem_req_val,
  input  logic                       mem_req_rdy,
  output logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
  output logic                       mem_req_rw,
  output logic                       mem_req_data_valid,
  input  logic                       mem_req_data_ready,
  output logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
  output logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                       mem_resp_val,
  input  logic [MEM_DATA_BITS-1:0]   mem_resp_data,

  output logic                       err_spurious
);

  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W  = $clog2(TAG_DEPTH + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(TAG_DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(TAG_DEPTH);

  typedef enum logic {IDLE = 1'b0, WDATA = 1'b1} state_t;

  state_t                 state, state_next;
  logic                   last_grant;   // 0 = ic, 1 = dc
  logic                   wr_owner;
  logic [BEAT_W-1:0]      wbeat, rbeat;
  logic [TAG_DEPTH-1:0]   tag_mem;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       tag_cnt;

  logic                   sel, sel_val, sel_rw, blocked;
  logic                   in_idle, in_wdata;
  logic                   req_fire, data_fire;
  logic                   fifo_full, fifo_empty, head, resp_hit, push, pop;

  // On contention the client not granted last wins; otherwise whoever is asking.
  assign sel      = (ic_req_val && dc_req_val) ? ~last_grant : dc_req_val;
  assign sel_val  = sel ? dc_req_val : ic_req_val;
  assign sel_rw   = sel ? dc_req_rw  : ic_req_rw;

  assign fifo_full  = (tag_cnt == FULL_CNT);
  assign fifo_empty = (tag_cnt == '0);
  assign blocked    = ~sel_rw & fifo_full;

  assign in_idle  = (state == IDLE)  && !reset;
  assign in_wdata = (state == WDATA) && !reset;

  assign mem_req_val  = in_idle & sel_val & ~blocked;
  assign mem_req_addr = sel ? dc_req_addr : ic_req_addr;
  assign mem_req_rw   = sel_rw;
  assign ic_req_rdy   = in_idle & ~sel & ~blocked & mem_req_rdy;
  assign dc_req_rdy   = in_idle &  sel & ~blocked & mem_req_rdy;
  assign req_fire     = mem_req_val & mem_req_rdy;

  assign mem_req_data_valid = in_wdata & (wr_owner ? dc_req_data_valid : ic_req_data_valid);
  assign mem_req_data_bits  = wr_owner ? dc_req_data_bits : ic_req_data_bits;
  assign mem_req_data_mask  = wr_owner ? dc_req_data_mask : ic_req_data_mask;
  assign ic_req_data_ready  = in_wdata & ~wr_owner & mem_req_data_ready;
  assign dc_req_data_ready  = in_wdata &  wr_owner & mem_req_data_ready;
  assign data_fire          = mem_req_data_valid & mem_req_data_ready;

  // Responses come back in request order, so the FIFO head names the owner.
  assign head         = tag_mem[rd_ptr];
  assign resp_hit     = mem_resp_val & ~fifo_empty & ~reset;
  assign ic_resp_val  = resp_hit & ~head;
  assign dc_resp_val  = resp_hit &  head;
  assign ic_resp_data = mem_resp_data;
  assign dc_resp_data = mem_resp_data;

  assign push = req_fire & ~sel_rw;
  assign pop  = resp_hit & (rbeat == LAST_BEAT);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_fire && sel_rw) state_next = WDATA;
      WDATA:   if (data_fire && (wbeat == LAST_BEAT)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= 1'b0;
      wr_owner     <= 1'b0;
      wbeat        <= '0;
      rbeat        <= '0;
      tag_mem      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      tag_cnt      <= '0;
      err_spurious <= 1'b0;
    end else begin
      state <= state_next;
      if (req_fire) begin
        last_grant <= sel;
        if (sel_rw) begin
          wr_owner <= sel;
          wbeat    <= '0;
        end
      end
      if (data_fire) wbeat <= wbeat + 1'b1;
      if (push) begin
        tag_mem[wr_ptr] <= sel;
        wr_ptr          <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (resp_hit) rbeat <= pop ? '0 : rbeat + 1'b1;
      if (pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      tag_cnt <= tag_cnt + 1'b1;
      else if (!push && pop) tag_cnt <= tag_cnt - 1'b1;
      if (mem_resp_val && fifo_empty) err_spurious <= 1'b1;
    end
  end

endmodule
